tnoc_flit_if_vc_sender: RTL

- Flit-interface transmitter: buffers flits per virtual channel and drives them onto one tnoc_flit_if sender port.
- Arbitrates round-robin between VCs at packet granularity. A packet, once granted, is sent to its tail flit before another VC is considered.
- Sits at router and NI output boundaries. It is the active counterpart that drives the receiver side of tnoc_flit_if (valid, flit) and obeys ready/vc_ready.

---
 rtl/tnoc_flit_if_vc_sender.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tnoc_flit_if_vc_sender.sv
// Flit-interface transmitter: per-VC flit FIFOs feeding one tnoc_flit_if
// sender port, with round-robin arbitration at packet granularity.

package tnoc_pkg;
    typedef struct packed {
        int virtual_channels;
    } tnoc_packet_config;

    localparam tnoc_packet_config TNOC_DEFAULT_PACKET_CONFIG = '{virtual_channels: 2};

    typedef struct packed {
        logic        head;
        logic        tail;
        logic [15:0] data;
    } tnoc_flit;
endpackage

interface tnoc_flit_if
    import tnoc_pkg::*;
#(
    parameter tnoc_packet_config PACKET_CONFIG = TNOC_DEFAULT_PACKET_CONFIG,
    parameter int                CHANNELS      = PACKET_CONFIG.virtual_channels
);
    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] vc_ready;
    tnoc_flit            flit;

    modport sender   (output valid, output flit, input  ready, input  vc_ready);
    modport receiver (input  valid, input  flit, output ready, output vc_ready);
endinterface

module tnoc_flit_if_vc_sender
    import tnoc_pkg::*;
#(
    parameter tnoc_packet_config PACKET_CONFIG = TNOC_DEFAULT_PACKET_CONFIG,
    parameter int                CHANNELS      = PACKET_CONFIG.virtual_channels,
    parameter int                FIFO_DEPTH    = 4
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [CHANNELS-1:0]      i_valid,
    output logic [CHANNELS-1:0]      o_ready,
    input  tnoc_flit [CHANNELS-1:0]  i_flit,
    output logic                     o_busy,
    tnoc_flit_if.sender              sender_if
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [CHANNELS-1:0] fifo_empty;
    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] fifo_push;
    logic [CHANNELS-1:0] fifo_pop;
    logic [CHANNELS-1:0] send_valid;
    logic [CHANNELS-1:0] eligible;
    tnoc_flit [CHANNELS-1:0] fifo_head;
    logic                found;
    int                  idx_int;
    logic [GW-1:0]       idx_g;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc_fifo
            tnoc_flit      mem_q [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_q;
            logic [PW-1:0] rd_ptr_q;
            logic [CW-1:0] count_q;

            assign fifo_empty[gi] = (count_q == '0);
            assign fifo_full[gi]  = (count_q == CW'(FIFO_DEPTH));
            // Full blocks the push even if a pop happens in the same cycle.
            assign fifo_push[gi]  = i_valid[gi] && !fifo_full[gi];
            assign fifo_head[gi]  = mem_q[rd_ptr_q];

            // Flit storage write; contents are meaningless until counted in.
            always_ff @(posedge i_clk) begin
                if (fifo_push[gi]) begin
                    mem_q[wr_ptr_q] <= i_flit[gi];
                end
            end

            // Pointer and occupancy tracking; pointers wrap naturally.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
                    case ({fifo_push[gi], fifo_pop[gi]})
                        2'b10:   count_q <= count_q + 1'b1;
                        2'b01:   count_q <= count_q - 1'b1;
                        default: count_q <= count_q;
                    endcase
                end
            end
        end
    endgenerate

    assign eligible = ~fifo_empty & sender_if.vc_ready;

    // Arbitration and packet-locked send control.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        send_valid   = '0;
        fifo_pop     = '0;
        found        = 1'b0;
        idx_int      = 0;
        idx_g        = '0;
        case (state_q)
            IDLE: begin
                // Search starts just after the VC that finished last.
                for (int i = 1; i <= CHANNELS; i++) begin
                    idx_int = (int'(last_grant_q) + i) % CHANNELS;
                    idx_g   = GW'(idx_int);
                    if (!found && eligible[idx_g]) begin
                        found   = 1'b1;
                        grant_d = idx_g;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                // Locked to grant until its tail leaves, even if it runs dry.
                if (!fifo_empty[grant_q]) begin
                    send_valid[grant_q] = 1'b1;
                    if (sender_if.ready[grant_q]) begin
                        fifo_pop[grant_q] = 1'b1;
                        if (fifo_head[grant_q].tail) begin
                            state_d      = IDLE;
                            last_grant_d = grant_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and grant registers; last grant resets to the top VC so VC0 goes first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GW'(CHANNELS - 1);
            last_grant_q <= GW'(CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_ready         = ~fifo_full;
    assign sender_if.valid = send_valid;
    assign sender_if.flit  = fifo_head[grant_q];
    assign o_busy          = (|(~fifo_empty)) || (state_q == SEND);

endmodule
